// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and types for the 64-word RAM DMA engine
// Purpose: word/address widths, operation and FSM state enums, length clamp.
// Ports: none (package).
package ram_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = ADDR_W + 1;
  localparam int MAX_LEN = 1 << ADDR_W;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } dma_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_WR,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_DONE
  } dma_state_e;

  // Lengths 65..127 are representable on the port but the RAM only has 64 words.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - word index counter and wrapping base+index address adder
// Purpose: holds the transfer index, produces (base + idx) mod 64 and a
//          terminal-count flag that is set while working on the last word.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   i_clr         restart index at 0 (new command)
//   i_inc         advance index by one (a word was written)
//   i_base        base address currently selected (src or dst)
//   i_len         clamped transfer length 1..64
//   o_addr        wrapped RAM address
//   o_last        current index is the final word
module dma_addr_gen
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [LEN_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + LEN_W'(1);
    end
  end

  // 6-bit add: the carry is dropped so the block wraps from 63 to 0.
  assign o_addr = i_base + r_idx[ADDR_W-1:0];
  assign o_last = (r_idx + LEN_W'(1)) >= i_len;

endmodule

// File: rtl/ram_dma64.sv
// rtl/ram_dma64.sv - FILL/COPY DMA initiator for the 64-word RAM
// Purpose: block fill with a constant or ascending word-by-word copy
//          (read then write per word) over the wrapping 64-word space.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, op               command strobe (IDLE only), 0=FILL 1=COPY
//   src_addr, dst_addr      copy source / destination base
//   len                     word count, values above 64 clamp to 64
//   fill_data               FILL value
//   busy, done              busy through the done cycle, one-cycle done pulse
//   mem_load, mem_address   RAM write enable and address
//   mem_wdata, mem_rdata    RAM write data, combinational RAM read data
module ram_dma64
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dma_state_e        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_hold;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_inc;
  logic [LEN_W-1:0]  w_len_c;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_inc    = (r_state == ST_FILL_WR) || (r_state == ST_COPY_WR);
  assign w_len_c  = clamp_len(len);
  // One adder serves both sides: source base only while reading.
  assign w_base   = (r_state == ST_COPY_RD) ? r_src : r_dst;

  dma_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_inc  (w_inc),
    .i_base (w_base),
    .i_len  (r_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_len  <= w_len_c;
            r_fill <= fill_data;
            r_busy <= 1'b1;
            if (w_len_c == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (dma_op_e'(op) == OP_COPY) begin
              r_state <= ST_COPY_RD;
            end else begin
              r_state <= ST_FILL_WR;
            end
          end
        end
        ST_FILL_WR: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_COPY_RD: begin
          r_hold  <= mem_rdata;
          r_state <= ST_COPY_WR;
        end
        ST_COPY_WR: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_COPY_RD;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_load    = w_inc;
  // Address and data are parked at zero when not transferring.
  assign mem_address = (w_inc || (r_state == ST_COPY_RD)) ? w_addr : '0;
  assign mem_wdata   = (r_state == ST_FILL_WR) ? r_fill :
                       (r_state == ST_COPY_WR) ? r_hold : '0;

endmodule

// File: tb/tb_ram_dma64.sv
// tb/tb_ram_dma64.sv - self-checking bench for ram_dma64 with a RAM and reference model
module tb_ram_dma64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [5:0]  src_addr;
  logic [5:0]  dst_addr;
  logic [6:0]  len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic        mem_load;
  logic [5:0]  mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  ram_dma64 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .fill_data   (fill_data),
    .busy        (busy),
    .done        (done),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram     [64];
  logic [15:0] pl_img  [64];
  logic [15:0] ref_mem [64];
  logic        pl_en;
  int          wr_log[$];
  int          rd_log[$];
  int          n_checks;
  int          n_errors;

  assign mem_rdata = ram[mem_address];

  always @(posedge clk) begin
    if (pl_en) ram <= pl_img;
    else if (mem_load) ram[mem_address] <= mem_wdata;
    if (mem_load) wr_log.push_back(int'(mem_address));
    else if (busy && !done) rd_log.push_back(int'(mem_address));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       pl_img[i] = 16'h0000;
        1:       pl_img[i] = 16'(i + 100);
        default: pl_img[i] = 16'($urandom);
      endcase
      ref_mem[i] = pl_img[i];
    end
    pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic compare_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic scramble_inputs();
    op        = 1'($urandom);
    src_addr  = 6'($urandom);
    dst_addr  = 6'($urandom);
    len       = 7'($urandom);
    fill_data = 16'($urandom);
  endtask

  task automatic run_op(input int opv, input int src, input int dst, input int ln,
                        input int fill, input bit poke);
    int n, wb, rb, cyc, lat, bad;
    n  = (ln > 64) ? 64 : ln;
    wb = wr_log.size();
    rb = rd_log.size();
    op = 1'(opv); src_addr = 6'(src); dst_addr = 6'(dst); len = 7'(ln); fill_data = 16'(fill);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    check("busy_after_start", 32'(busy), 1);
    cyc = 1;
    while (!done && cyc < 300) begin
      if (poke && cyc == 2) begin
        start = 1'b1;
        scramble_inputs();
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    lat = (n == 0) ? 1 : (opv != 0) ? 2 * n + 1 : n + 1;
    check("done_seen", 32'(done), 1);
    check("latency", cyc, lat);
    check("busy_with_done", 32'(busy), 1);
    check("no_load_in_done", 32'(mem_load), 0);
    if (poke) begin
      start = 1'b1;
      scramble_inputs();
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);

    check("wr_count", wr_log.size() - wb, n);
    bad = 0;
    for (int i = 0; i < n && wb + i < wr_log.size(); i++)
      if (wr_log[wb + i] != (dst + i) % 64) bad++;
    check("wr_addrs", bad, 0);
    check("rd_count", rd_log.size() - rb, (opv != 0) ? n : 0);
    bad = 0;
    if (opv != 0)
      for (int i = 0; i < n && rb + i < rd_log.size(); i++)
        if (rd_log[rb + i] != (src + i) % 64) bad++;
    check("rd_addrs", bad, 0);

    for (int i = 0; i < n; i++)
      ref_mem[(dst + i) % 64] = (opv != 0) ? ref_mem[(src + i) % 64] : 16'(fill);
    compare_ram("ram_contents");
  endtask

  initial begin
    int wb, cyc;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    pl_en = 1'b0;
    preload(0);
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load", 32'(mem_load), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 10, 4, 16'hBEEF, 1'b0);
    check("ram10", 32'(ram[10]), 16'hBEEF);
    check("ram13", 32'(ram[13]), 16'hBEEF);
    check("ram9", 32'(ram[9]), 0);
    check("ram14", 32'(ram[14]), 0);

    preload(1);
    run_op(1, 0, 32, 8, 0, 1'b0);
    check("ram39", 32'(ram[39]), 107);

    run_op(0, 0, 62, 4, 16'h0001, 1'b0);
    run_op(1, 60, 20, 8, 0, 1'b0);

    preload(2);
    run_op(1, 0, 1, 3, 0, 1'b0);
    check("smear3", 32'(ram[3]), 32'(ram[0]));

    run_op(0, 0, 5, 0, 16'h1234, 1'b0);
    run_op(0, 0, 17, 100, 16'h5A5A, 1'b0);
    run_op(1, 7, 7, 5, 0, 1'b1);

    // Abort a COPY after three words have been written.
    preload(2);
    wb = wr_log.size();
    op = 1'b1; src_addr = 6'd0; dst_addr = 6'd40; len = 7'd10; fill_data = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (wr_log.size() - wb < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached", 32'(wr_log.size() - wb), 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_load", 32'(mem_load), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_wr_count", wr_log.size() - wb, 3);
    for (int i = 0; i < 3; i++) ref_mem[40 + i] = ref_mem[i];
    compare_ram("abort_ram");

    for (int k = 0; k < 12; k++)
      run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 100)),
             int'($urandom_range(0, 65535)), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
